input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
//
// PURPOSE
//   Multi-channel conditioning front end for asynchronous inputs (buttons, mode pins) of the counter.
//   Each channel has a SYNC_STAGES-deep synchronizer chain, a per-channel debounce counter and registered
//   rise/fall edge detection. It sits between the raw ui_in pins and the counter control FSM. It replaces
//   the single-stage register bank and adds glitch rejection plus single-cycle edge pulses.
//
// PARAMETERS
//   DIGITS           6   number of independent input channels
//   SYNC_STAGES      2   flops per synchronizer chain; legal range >= 1
//   DEBOUNCE_CYCLES  4   consecutive cycles a new synchronized value must hold before acceptance; legal range >= 1
//
// PORTS
//   clk        input   1       system clock; all flops are on its rising edge
//   reset      input   1       synchronous, active-high reset
//   data_in    input   DIGITS  asynchronous raw inputs, one bit per channel
//   data_out   output  DIGITS  debounced, synchronous level per channel
//   rise_out   output  DIGITS  one-cycle pulse when data_out[i] goes 0->1
//   fall_out   output  DIGITS  one-cycle pulse when data_out[i] goes 1->0
//
// BEHAVIOUR
//   - Reset, synchronous and active-high, takes priority over everything else. It clears the following to 0:
//     every sync stage, every debounce counter, data_out, rise_out and fall_out.
//   - Sync chain per channel: stage[0] <= data_in[i], then stage[k] <= stage[k-1]; s[i] = stage[SYNC_STAGES-1].
//   - Debounce counter per channel, CNT_W = $clog2(DEBOUNCE_CYCLES+1) bits.
//     - If s[i] == data_out[i]: cnt <= 0.
//     - If s[i] != data_out[i] and cnt == DEBOUNCE_CYCLES-1: data_out[i] <= s[i], cnt <= 0.
//     - Otherwise, when s[i] != data_out[i]: cnt <= cnt + 1. The counter never wraps.
//   - Glitch rejection: if s[i] returns to data_out[i] before acceptance, the counter clears. There is no
//     partial credit; a later change restarts from 0.
//   - Edge pulses are registered in the same edge that updates data_out[i]:
//     - rise_out[i] <= ~data_out[i] & accept[i] & s[i]
//     - fall_out[i] <= data_out[i] & accept[i] & ~s[i]
//     - Each pulse is exactly 1 cycle wide. rise and fall are never both high on one channel.
//   - Latency: take a data_in[i] change sampled at edge 1 and held stable.
//     - s[i] changes after edge SYNC_STAGES.
//     - data_out[i] and the pulse assert after edge SYNC_STAGES+DEBOUNCE_CYCLES (6 with defaults).
//     - The pulse clears on the next edge.
//   - Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
//   - Reset mid-debounce: pending counts are discarded and no pulse is emitted. After release, an input held
//     at 1 is treated as a fresh 0->1 change. It produces rise_out exactly SYNC_STAGES+DEBOUNCE_CYCLES edges
//     after the first non-reset edge.
//   - DEBOUNCE_CYCLES=1: a change is accepted on the first edge s[i] differs; the block then acts as a pure
//     synchronizer with edge detection.
//   - There are no combinational paths from data_in to any output. All outputs are registered.
//
// TESTING (defaults unless stated)
//   1. reset=1 for 3 cycles, data_in=6'h3F
//      -> all outputs 0 during reset;
//      -> data_out=6'h3F and rise_out=6'h3F on edge 6 after release;
//      -> rise_out=0 on edge 7.
//   2. data_in[0] high for 3 cycles then low
//      -> data_out[0], rise_out[0] and fall_out[0] stay 0 throughout.
//   3. data_in[2] 0->1, held 20 cycles, then 1->0
//      -> rise_out[2] is a 1-cycle pulse 6 edges after the rise;
//      -> fall_out[2] is a 1-cycle pulse 6 edges after the fall;
//      -> other bits stay 0.
//   4. data_in[0] rises at edge t and data_in[5] rises at edge t+2
//      -> rise_out[0] at t+6, rise_out[5] at t+8, never overlapping.
//   5. data_in[1] 0->1, then reset pulsed for 1 cycle 4 edges later with input still high
//      -> no pulse before reset;
//      -> rise_out[1] 6 edges after the first non-reset edge.
//   6. Rebuild with SYNC_STAGES=3, DEBOUNCE_CYCLES=1, and toggle data_in[3] every 10 cycles
//      -> data_out[3] follows with latency 4;
//      -> alternating rise/fall pulses, each 1 cycle wide.

Source files
------------

// File: rtl/input_conditioner_if.sv
// Pin-side bundle for the input conditioner: raw channel inputs plus the
// debounced levels and single-cycle edge pulses.
interface input_conditioner_if #(
   parameter int DIGITS = 6
);
   logic [DIGITS-1:0] data_in;
   logic [DIGITS-1:0] data_out;
   logic [DIGITS-1:0] rise_out;
   logic [DIGITS-1:0] fall_out;

   modport master (
      output data_in,
      input  data_out,
      input  rise_out,
      input  fall_out
   );

   modport slave (
      input  data_in,
      output data_out,
      output rise_out,
      output fall_out
   );
endinterface

// File: rtl/input_conditioner.sv
// Multi-channel input front end: per-channel synchronizer chain, debounce
// counter and registered rise/fall pulses. All outputs come straight from flops.
module input_conditioner #(
   parameter int DIGITS          = 6,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input logic                clk,
   input logic                reset,
   input_conditioner_if.slave bus
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] stage [DIGITS];
   logic [CNT_W-1:0]       cnt   [DIGITS];
   logic [DIGITS-1:0]      s;
   logic [DIGITS-1:0]      accept;
   logic [DIGITS-1:0]      level;
   logic [DIGITS-1:0]      rise;
   logic [DIGITS-1:0]      fall;

   // accept is high on the edge where a differing level has held long enough
   always_comb begin
      s      = '0;
      accept = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         s[i]      = stage[i][SYNC_STAGES-1];
         accept[i] = (s[i] != level[i]) && (cnt[i] == CNT_LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DIGITS; i++) begin
            stage[i] <= '0;
            cnt[i]   <= '0;
         end
         level <= '0;
         rise  <= '0;
         fall  <= '0;
      end else begin
         for (int unsigned i = 0; i < DIGITS; i++) begin
            stage[i][0] <= bus.data_in[i];
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
               stage[i][k] <= stage[i][k-1];
            end
            if (s[i] == level[i]) begin
               cnt[i] <= '0;
            end else if (accept[i]) begin
               level[i] <= s[i];
               cnt[i]   <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
         rise <= ~level & accept & s;
         fall <= level & accept & ~s;
      end
   end

   assign bus.data_out = level;
   assign bus.rise_out = rise;
   assign bus.fall_out = fall;
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: default build plus a
// SYNC_STAGES=3 / DEBOUNCE_CYCLES=1 build sharing clock and reset.
module tb_input_conditioner;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   input_conditioner_if #(.DIGITS(6)) if1 ();
   input_conditioner_if #(.DIGITS(6)) if2 ();

   input_conditioner #(
      .DIGITS(6), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk(clk), .reset(reset), .bus(if1.slave)
   );

   input_conditioner #(
      .DIGITS(6), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)
   ) dut2 (
      .clk(clk), .reset(reset), .bus(if2.slave)
   );

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      if1.data_in = '0;
      if2.data_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      if1.data_in = 6'h3F;
      if2.data_in = '0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checks++;
         if ({if1.data_out, if1.rise_out, if1.fall_out} !== 18'h0) begin
            errors++;
            $display("FAIL reset_hold cyc %0d: out=%h rise=%h fall=%h required all 0",
                     c, if1.data_out, if1.rise_out, if1.fall_out);
         end
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         logic [5:0] exp_d, exp_r;
         @(posedge clk); #1;
         exp_d = (i >= 6) ? 6'h3F : 6'h00;
         exp_r = (i == 6) ? 6'h3F : 6'h00;
         checks++;
         if (if1.data_out !== exp_d || if1.rise_out !== exp_r || if1.fall_out !== 6'h00) begin
            errors++;
            $display("FAIL reset_release edge %0d: out=%h rise=%h fall=%h required out=%h rise=%h fall=00",
                     i, if1.data_out, if1.rise_out, if1.fall_out, exp_d, exp_r);
         end
      end
   endtask

   task automatic test_glitch();
      do_reset();
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if1.data_in[0] = (i <= 3);
         @(posedge clk); #1;
         checks++;
         if ({if1.data_out, if1.rise_out, if1.fall_out} !== 18'h0) begin
            errors++;
            $display("FAIL glitch edge %0d: out=%h rise=%h fall=%h required all 0",
                     i, if1.data_out, if1.rise_out, if1.fall_out);
         end
      end
   endtask

   task automatic test_rise_fall();
      do_reset();
      // rise applied before edge 1, fall before edge 21
      for (int i = 1; i <= 32; i++) begin
         logic [5:0] exp_d, exp_r, exp_f;
         @(negedge clk);
         if (i == 1)  if1.data_in[2] = 1'b1;
         if (i == 21) if1.data_in[2] = 1'b0;
         @(posedge clk); #1;
         exp_d = (i >= 6 && i < 26) ? 6'h04 : 6'h00;
         exp_r = (i == 6)  ? 6'h04 : 6'h00;
         exp_f = (i == 26) ? 6'h04 : 6'h00;
         checks++;
         if (if1.data_out !== exp_d || if1.rise_out !== exp_r || if1.fall_out !== exp_f) begin
            errors++;
            $display("FAIL rise_fall edge %0d: out=%h rise=%h fall=%h required out=%h rise=%h fall=%h",
                     i, if1.data_out, if1.rise_out, if1.fall_out, exp_d, exp_r, exp_f);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 1; i <= 12; i++) begin
         logic [5:0] exp_r;
         @(negedge clk);
         if (i == 1) if1.data_in[0] = 1'b1;
         if (i == 3) if1.data_in[5] = 1'b1;
         @(posedge clk); #1;
         exp_r = (i == 6) ? 6'h01 : (i == 8) ? 6'h20 : 6'h00;
         checks++;
         if (if1.rise_out !== exp_r || if1.fall_out !== 6'h00) begin
            errors++;
            $display("FAIL back_to_back edge %0d: rise=%h fall=%h required rise=%h fall=00",
                     i, if1.rise_out, if1.fall_out, exp_r);
         end
      end
   endtask

   task automatic test_reset_mid_debounce();
      do_reset();
      for (int i = 1; i <= 14; i++) begin
         logic [5:0] exp_d, exp_r;
         @(negedge clk);
         if (i == 1) if1.data_in[1] = 1'b1;
         reset = (i == 5);
         @(posedge clk); #1;
         exp_d = (i >= 11) ? 6'h02 : 6'h00;
         exp_r = (i == 11) ? 6'h02 : 6'h00;
         checks++;
         if (if1.data_out !== exp_d || if1.rise_out !== exp_r || if1.fall_out !== 6'h00) begin
            errors++;
            $display("FAIL reset_mid edge %0d: out=%h rise=%h fall=%h required out=%h rise=%h fall=00",
                     i, if1.data_out, if1.rise_out, if1.fall_out, exp_d, exp_r);
         end
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_sync_only();
      do_reset();
      // toggles before edges 1, 11, 21, 31; latency 4 edges
      for (int i = 1; i <= 40; i++) begin
         logic [5:0] exp_d, exp_r, exp_f;
         @(negedge clk);
         if ((i % 10) == 1) if2.data_in[3] = ~if2.data_in[3];
         @(posedge clk); #1;
         exp_d = ((i >= 4 && i < 14) || (i >= 24 && i < 34)) ? 6'h08 : 6'h00;
         exp_r = (i == 4  || i == 24) ? 6'h08 : 6'h00;
         exp_f = (i == 14 || i == 34) ? 6'h08 : 6'h00;
         checks++;
         if (if2.data_out !== exp_d || if2.rise_out !== exp_r || if2.fall_out !== exp_f) begin
            errors++;
            $display("FAIL sync_only edge %0d: out=%h rise=%h fall=%h required out=%h rise=%h fall=%h",
                     i, if2.data_out, if2.rise_out, if2.fall_out, exp_d, exp_r, exp_f);
         end
      end
   endtask

   initial begin
      if1.data_in = '0;
      if2.data_in = '0;
      test_reset();
      test_glitch();
      test_rise_fall();
      test_back_to_back();
      test_reset_mid_debounce();
      test_sync_only();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
